// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU opcodes and shift-amount sizing.
package exe_pkg;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd12;

  function automatic int shamt_w(input int data_w);
    return $clog2(data_w);
  endfunction
endpackage

// File: rtl/exe_alu.sv
// Combinational single-cycle ALU; MUL and unused opcodes yield 0 here.
module exe_alu
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result
);
  localparam int SH_W = shamt_w(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = src1[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_NOR:  result = ~(src1 | src2);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (src1 < src2)};
      ALU_SLL:  result = src2 << sh;
      ALU_SRL:  result = src2 >> sh;
      ALU_SRA:  result = $unsigned($signed(src2) >>> sh);
      ALU_LUI:  result = src2 << (DATA_W/2);
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: valid/allowin handshake, EXE/WB forwarding, load-use stall
// detection and a latency-counted multi-cycle MUL.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int OP_W    = ALU_OP_W,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_valid,
  output logic              exe_allowin,
  input  logic [OP_W-1:0]   de_aluop,
  input  logic [DATA_W-1:0] de_src1,
  input  logic [DATA_W-1:0] de_src2,
  input  logic [REG_W-1:0]  de_rs,
  input  logic [REG_W-1:0]  de_rt,
  input  logic              de_use_rs,
  input  logic              de_use_rt,
  input  logic              de_wen,
  input  logic [REG_W-1:0]  de_dest,
  input  logic              de_is_load,
  input  logic              mem_allowin,
  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_result,
  output logic              exe_wen,
  output logic [REG_W-1:0]  exe_dest,
  output logic              exe_is_load,
  input  logic              wb_wen,
  input  logic [REG_W-1:0]  wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              load_use_stall
);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              wen;
    logic [REG_W-1:0]  dest;
    logic              is_load;
  } mul_req_t;

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  mul_req_t          mreq;
  logic [DATA_W-1:0] op1, op2, alu_res, mul_now, mul_done;
  logic              exe_fwd_ok, fwd_exe1, fwd_wb1, fwd_exe2, fwd_wb2;
  logic              accept, consume, is_mul;

  // A load's EXE result is only its address, so it must never be forwarded.
  assign exe_fwd_ok = exe_valid & exe_wen & ~exe_is_load & (exe_dest != '0);
  assign fwd_exe1   = de_use_rs & exe_fwd_ok & (exe_dest == de_rs);
  assign fwd_exe2   = de_use_rt & exe_fwd_ok & (exe_dest == de_rt);
  assign fwd_wb1    = de_use_rs & wb_wen & (wb_dest != '0) & (wb_dest == de_rs);
  assign fwd_wb2    = de_use_rt & wb_wen & (wb_dest != '0) & (wb_dest == de_rt);
  assign op1 = fwd_exe1 ? exe_result : fwd_wb1 ? wb_data : de_src1;
  assign op2 = fwd_exe2 ? exe_result : fwd_wb2 ? wb_data : de_src2;

  assign load_use_stall = de_valid & exe_valid & exe_is_load & exe_wen & (exe_dest != '0) &
                          ((de_use_rs & (de_rs == exe_dest)) | (de_use_rt & (de_rt == exe_dest)));
  assign exe_allowin = ~busy & ~load_use_stall & (~exe_valid | mem_allowin);
  assign accept      = de_valid & exe_allowin;
  assign consume     = exe_valid & mem_allowin;
  assign is_mul      = (de_aluop == ALU_MUL);
  assign mul_now     = op1 * op2;
  assign mul_done    = mreq.a * mreq.b;

  exe_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op(de_aluop), .src1(op1), .src2(op2), .result(alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid   <= 1'b0;
      exe_result  <= '0;
      exe_wen     <= 1'b0;
      exe_dest    <= '0;
      exe_is_load <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      mreq        <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        busy        <= 1'b0;
        exe_valid   <= 1'b1;
        exe_result  <= mul_done;
        exe_wen     <= mreq.wen;
        exe_dest    <= mreq.dest;
        exe_is_load <= mreq.is_load;
      end
    end else if (accept && is_mul && (MUL_LAT > 1)) begin
      // Slot is free here: allowin guaranteed it empty or being consumed.
      busy      <= 1'b1;
      cnt       <= CNT_W'(MUL_LAT - 1);
      exe_valid <= 1'b0;
      mreq      <= '{a: op1, b: op2, wen: de_wen, dest: de_dest, is_load: de_is_load};
    end else if (accept) begin
      exe_valid   <= 1'b1;
      exe_result  <= is_mul ? mul_now : alu_res;
      exe_wen     <= de_wen;
      exe_dest    <= de_dest;
      exe_is_load <= de_is_load;
    end else if (consume) begin
      exe_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exe_stage_pipe.sv
// Self-checking bench for exe_stage_pipe: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exe_stage_pipe;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic        clk, reset;
  logic        de_valid, exe_allowin;
  logic [3:0]  de_aluop;
  logic [31:0] de_src1, de_src2;
  logic [4:0]  de_rs, de_rt, de_dest;
  logic        de_use_rs, de_use_rt, de_wen, de_is_load;
  logic        mem_allowin;
  logic        exe_valid, exe_wen, exe_is_load;
  logic [31:0] exe_result;
  logic [4:0]  exe_dest;
  logic        wb_wen;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        load_use_stall;

  exe_stage_pipe #(.DATA_W(DW), .REG_W(5), .OP_W(4), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .exe_allowin(exe_allowin),
    .de_aluop(de_aluop), .de_src1(de_src1), .de_src2(de_src2), .de_rs(de_rs),
    .de_rt(de_rt), .de_use_rs(de_use_rs), .de_use_rt(de_use_rt), .de_wen(de_wen),
    .de_dest(de_dest), .de_is_load(de_is_load), .mem_allowin(mem_allowin),
    .exe_valid(exe_valid), .exe_result(exe_result), .exe_wen(exe_wen),
    .exe_dest(exe_dest), .exe_is_load(exe_is_load), .wb_wen(wb_wen),
    .wb_dest(wb_dest), .wb_data(wb_data), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit model_ok = 0;

  // Model state: what the stage should be presenting after each edge.
  logic        m_valid, m_wen, m_load, m_busy;
  logic [31:0] m_result, p_result;
  logic [4:0]  m_dest, p_dest;
  logic        p_wen, p_load;
  int          m_edge, m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    int sh;
    sh = int'(a & 32'h1f);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: begin w = {{32{b[31]}}, b}; w = w >> sh; return w[31:0]; end
      4'd11: return b << 16;
      4'd12: begin w = 64'(a) * 64'(b); return w[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic use_r, input logic [4:0] r, input logic [31:0] src);
    if (use_r && r != 0 && m_valid && m_wen && !m_load && m_dest == r) return m_result;
    if (use_r && r != 0 && wb_wen && wb_dest == r) return wb_data;
    return src;
  endfunction

  function automatic logic exp_stall();
    if (!(de_valid && m_valid && m_load && m_wen && m_dest != 0)) return 1'b0;
    return (de_use_rs && de_rs == m_dest) || (de_use_rt && de_rt == m_dest);
  endfunction

  function automatic logic exp_allowin();
    return !m_busy && !exp_stall() && (!m_valid || mem_allowin);
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    if (reset) begin
      m_valid = 0; m_result = 0; m_wen = 0; m_dest = 0; m_load = 0; m_busy = 0;
    end else if (m_busy) begin
      if (m_edge == m_done) begin
        m_busy = 0; m_valid = 1; m_result = p_result; m_wen = p_wen; m_dest = p_dest; m_load = p_load;
      end
    end else if (de_valid && exp_allowin()) begin
      r = ref_alu(de_aluop, fwd(de_use_rs, de_rs, de_src1), fwd(de_use_rt, de_rt, de_src2));
      if (de_aluop == 4'd12 && LAT > 1) begin
        m_busy = 1; m_done = m_edge + LAT - 1; m_valid = 0;
        p_result = r; p_wen = de_wen; p_dest = de_dest; p_load = de_is_load;
      end else begin
        m_valid = 1; m_result = r; m_wen = de_wen; m_dest = de_dest; m_load = de_is_load;
      end
    end else if (m_valid && mem_allowin) begin
      m_valid = 0;
    end
    m_edge++;
  endtask

  // Called just after a falling edge with inputs already set: compare, advance model, cross one rising edge.
  task automatic tick();
    #1;
    if (model_ok) begin
      chk("exe_valid",      exe_valid,      m_valid);
      chk("exe_result",     exe_result,     m_result);
      chk("exe_wen",        exe_wen,        m_wen);
      chk("exe_dest",       exe_dest,       m_dest);
      chk("exe_is_load",    exe_is_load,    m_load);
      chk("exe_allowin",    exe_allowin,    exp_allowin());
      chk("load_use_stall", load_use_stall, exp_stall());
    end
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_de(input logic v, input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic urs, input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                        input logic wen, input logic [4:0] dest, input logic ld);
    de_valid = v; de_aluop = op; de_src1 = s1; de_src2 = s2;
    de_use_rs = urs; de_rs = rs; de_use_rt = urt; de_rt = rt;
    de_wen = wen; de_dest = dest; de_is_load = ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; mem_allowin = 1; wb_wen = 0; wb_dest = 0; wb_data = 0;
    set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_valid = 0; m_result = 0; m_wen = 0; m_dest = 0; m_load = 0; m_busy = 0;
    p_result = 0; p_wen = 0; p_dest = 0; p_load = 0; m_edge = 0; m_done = 0;
    @(negedge clk);
    model_ok = 1;
    repeat (3) tick();
    reset = 0;
    #1;
    chk("rst_valid", exe_valid, 0);
    chk("rst_result", exe_result, 0);
    chk("rst_allowin", exe_allowin, 1);
    tick();

    // Basic ALU ops
    set_de(1, 4'd0, 5, 7, 0, 0, 0, 0, 1, 1, 0); tick();
    chk("add_5_7", exe_result, 12);
    chk("add_valid", exe_valid, 1);
    set_de(1, 4'd1, 3, 5, 0, 0, 0, 0, 1, 2, 0); tick();
    chk("sub_3_5", exe_result, 32'hFFFF_FFFE);

    // Forwarding priority: EXE over WB, then WB alone, then r0 never forwarded
    set_de(1, 4'd0, 32'h11, 0, 0, 0, 0, 0, 1, 3, 0); tick();
    wb_wen = 1; wb_dest = 3; wb_data = 32'h22;
    set_de(1, 4'd0, 32'hdead, 1, 1, 3, 1, 0, 1, 5, 0); tick();
    chk("fwd_exe_prio", exe_result, 32'h12);
    de_valid = 0; tick();
    set_de(1, 4'd0, 32'hdead, 1, 1, 3, 1, 0, 1, 5, 0); tick();
    chk("fwd_wb", exe_result, 32'h23);
    wb_wen = 0;
    set_de(1, 4'd0, 32'h11, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    wb_wen = 1; wb_dest = 0; wb_data = 32'h99;
    set_de(1, 4'd0, 32'h40, 1, 1, 0, 0, 0, 1, 5, 0); tick();
    chk("fwd_r0_none", exe_result, 32'h41);
    wb_wen = 0;

    // Load-use stall
    set_de(1, 4'd0, 32'h100, 4, 0, 0, 0, 0, 1, 4, 1); tick();
    mem_allowin = 0;
    set_de(1, 4'd0, 1, 9, 0, 0, 1, 4, 1, 6, 0);
    #1;
    chk("lu_stall", load_use_stall, 1);
    chk("lu_allowin", exe_allowin, 0);
    tick();
    mem_allowin = 1; tick();
    #1;
    chk("lu_cleared", load_use_stall, 0);
    chk("lu_allowin_back", exe_allowin, 1);
    tick();
    chk("lu_result", exe_result, 10);

    // Multi-cycle MUL; decode keeps offering an ADD that must wait
    set_de(1, 4'd12, 6, 7, 0, 0, 0, 0, 1, 7, 0); tick();
    set_de(1, 4'd0, 1, 1, 0, 0, 0, 0, 1, 8, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mul_busy_allowin", exe_allowin, 0);
      tick();
    end
    chk("mul_valid", exe_valid, 1);
    chk("mul_42", exe_result, 42);
    tick();
    chk("after_mul_add", exe_result, 2);

    // Reset during the second busy cycle aborts the MUL
    set_de(1, 4'd12, 3, 5, 0, 0, 0, 0, 1, 9, 0); tick();
    de_valid = 0; tick();
    reset = 1; tick();
    reset = 0;
    #1;
    chk("mulrst_allowin", exe_allowin, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mulrst_no_result", exe_valid, 0);
    end

    // Backpressure
    set_de(1, 4'd0, 1, 2, 0, 0, 0, 0, 1, 8, 0); tick();
    mem_allowin = 0;
    set_de(1, 4'd0, 10, 20, 0, 0, 0, 0, 1, 9, 0);
    #1;
    chk("bp_allowin", exe_allowin, 0);
    tick();
    chk("bp_hold_result", exe_result, 3);
    chk("bp_hold_valid", exe_valid, 1);
    mem_allowin = 1; tick();
    chk("bp_release_result", exe_result, 30);
    chk("bp_release_valid", exe_valid, 1);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      de_valid    = ($urandom_range(0, 9) < 7);
      de_aluop    = 4'($urandom_range(0, 15));
      de_src1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      de_src2     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      de_rs       = 5'($urandom_range(0, 7));
      de_rt       = 5'($urandom_range(0, 7));
      de_use_rs   = 1'($urandom_range(0, 1));
      de_use_rt   = 1'($urandom_range(0, 1));
      de_wen      = ($urandom_range(0, 9) < 8);
      de_dest     = 5'($urandom_range(0, 7));
      de_is_load  = ($urandom_range(0, 3) == 0);
      mem_allowin = ($urandom_range(0, 3) != 0);
      wb_wen      = 1'($urandom_range(0, 1));
      wb_dest     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Parametrised execute stage for the 5-stage CPU; sits between decode and memory.
- Adds over the previous execute stage: valid/allowin handshake, EXE/WB forwarding with a defined priority, load-use stall detection, and an iterative multi-cycle MUL.
- Single-cycle ALU ops retire into the EXE output register one edge after acceptance.

Parameters:
DATA_W, 32, datapath width (power of two, >=8)
REG_W, 5, register-index width
OP_W, 4, ALU opcode width
MUL_LAT, 4, MUL latency in cycles from acceptance to exe_valid (>=1; 1 = single-cycle)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
de_valid  in  1  decode holds a valid instruction
exe_allowin  out  1  stage accepts de_* this cycle
de_aluop  in  OP_W  operation code
de_src1  in  DATA_W  operand 1 (from register file/immediate)
de_src2  in  DATA_W  operand 2
de_rs  in  REG_W  source reg of operand 1
de_rt  in  REG_W  source reg of operand 2
de_use_rs  in  1  operand 1 comes from de_rs (forwardable)
de_use_rt  in  1  operand 2 comes from de_rt
de_wen  in  1  instruction writes a register
de_dest  in  REG_W  destination register
de_is_load  in  1  instruction is a load
mem_allowin  in  1  memory stage accepts EXE output
exe_valid  out  1  EXE output register holds a valid instruction
exe_result  out  DATA_W  registered result
exe_wen  out  1  registered write enable
exe_dest  out  REG_W  registered destination
exe_is_load  out  1  registered load flag
wb_wen  in  1  write-back stage writes this cycle
wb_dest  in  REG_W  write-back destination
wb_data  in  DATA_W  write-back data
load_use_stall  out  1  combinational hazard flag

Behaviour:
- Reset: exe_valid, exe_result, exe_wen, exe_dest, exe_is_load, busy, counter all 0. Reset during a MUL aborts it; no result is produced.
- Accept = de_valid & exe_allowin.
- exe_allowin = ~busy & ~load_use_stall & (~exe_valid | mem_allowin).
- Output consumed = exe_valid & mem_allowin. If consumed with no retire in the same cycle, exe_valid drops to 0 on the next edge.
- Forwarding, operand 1 (operand 2 identical with rt):
  - Priority 1, EXE: de_use_rs & exe_valid & exe_wen & ~exe_is_load & exe_dest!=0 & exe_dest==de_rs -> exe_result.
  - Priority 2, WB: de_use_rs & wb_wen & wb_dest!=0 & wb_dest==de_rs -> wb_data.
  - Otherwise de_src1.
  - Register 0 is never forwarded.
- load_use_stall = de_valid & exe_valid & exe_is_load & exe_wen & exe_dest!=0 & ((de_use_rs & de_rs==exe_dest) | (de_use_rt & de_rt==exe_dest)).
- Single-cycle op accepted: on the same edge, result, wen, dest and is_load are loaded into the output register; exe_valid=1.
- MUL accepted with MUL_LAT>1:
  - Forwarded operands and control are captured internally; busy=1, counter=MUL_LAT-1, exe_valid=0 (the slot was freed by the allowin rule).
  - Counter decrements each cycle. On the edge where counter goes 1->0: output register loads the product, exe_valid=1, busy=0.
  - While busy: exe_allowin=0; de_* are ignored.
- Ops (OP_W=4):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU (unsigned); result is 1 or 0.
  - 8 SLL, 9 SRL, 10 SRA: value src2, amount src1[log2(DATA_W)-1:0].
  - 11 LUI: src2<<(DATA_W/2).
  - 12 MUL: low DATA_W bits of the unsigned product.
  - 13-15: result 0.
  - ADD/SUB wrap modulo 2^DATA_W; no overflow trap.
- Simultaneous consume and accept: the output register is overwritten with the new instruction in the same edge; exe_valid stays 1.
- No accept and no consume: output register holds its contents.

Decomposition:
- Package exe_pkg: ALU opcode constants (ALU_ADD..ALU_MUL), op-width constant, helper function for shift-amount width.
- Sub-module exe_alu: combinational single-cycle ALU (ops 0-11, 13-15).
- The MUL sequencer, forwarding muxes, and the hazard/handshake logic stay in exe_stage_pipe.

Test Plan:
- Reset held 3 cycles, then released with de_valid=0 -> all outputs 0, exe_allowin=1.
- ADD src1=5, src2=7, mem_allowin=1 -> next edge: exe_result=12, exe_valid=1. SUB 3-5 -> 0xFFFFFFFE.
- Forwarding priority: EXE holds dest=3 (result 0x11) and WB writes r3=0x22; next ADD rs=3, rt=0, src2=1 -> 0x12. Same with exe_valid=0 -> 0x23. With dest=0 -> no forwarding.
- Load-use: EXE holds a load with dest=4; DE instruction uses rt=4 -> load_use_stall=1, exe_allowin=0. Drop exe_valid -> accepted.
- MUL 6x7, MUL_LAT=4 -> exe_allowin=0 for 3 cycles; exe_valid=1 with result 42 three edges after acceptance. Reset asserted in the 2nd busy cycle -> no result, busy=0.
- Backpressure: mem_allowin=0 with exe_valid=1 -> exe_allowin=0 and outputs stable. Release -> next instruction loads on the same edge; exe_valid stays 1.
